pkt_field_extractor: RTL and testbench
======================================

PKT_FIELD_EXTRACTOR -- requirements
Module: pkt_field_extractor

Interface
REQ-001 Parameter ADDR_W, default 11: packet-memory address width (2048-byte memory).
REQ-002 Parameter HB_TYPE, default 8'h01: packet type code for heartbeat.
REQ-003 Parameter DATA_TYPE, default 8'h02: packet type code for neighbour-info packets.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 nrst  in  1  asynchronous, active-high reset; port name kept per codebase naming.
REQ-006 pktStart  in  1  one-cycle request to parse the packet at pktBaseAddr.
REQ-007 pktBaseAddr  in  ADDR_W  address of packet byte 0, sampled with pktStart.
REQ-008 memRdEn  out  1  packet-memory read strobe.
REQ-009 memRdAddr  out  ADDR_W  packet-memory byte address.
REQ-010 memRdData  in  8  read data, valid exactly one cycle after memRdEn/memRdAddr.
REQ-011 fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH  out  16 each  extracted fields for the downstream Q-table update stage.
REQ-012 en  out  1  one-cycle strobe: fields valid, neighbour packet ready.
REQ-013 HB_Reset  out  1  one-cycle strobe on a valid heartbeat packet.
REQ-014 busy  out  1  high from accepted pktStart until the final strobe cycle, inclusive.
REQ-015 badPkt  out  1  one-cycle strobe on an unknown type or failed check.

Function
REQ-016 Packet layout: byte0 = type; bytes 1-12 = six big-endian 16-bit words in the REQ-011 order.
REQ-017 FSM states: IDLE, FETCH, CHECK, ISSUE.
REQ-018 IDLE: pktStart=1 latches pktBaseAddr, moves to FETCH, and raises busy on the next cycle.
REQ-019 FETCH issues one read per cycle, base+0 through base+N-1, memRdEn=1; N=13, or 14 with REQ-029.
REQ-020 Address arithmetic is modulo 2^ADDR_W: base 2047 wraps to address 0.
REQ-021 Each returned byte is assembled one cycle after its read; high byte lands in word[15:8], low byte in word[7:0].
REQ-022 Field registers are shadowed internally; visible outputs update only in ISSUE and hold until the next ISSUE.
REQ-023 CHECK, one cycle after the last byte arrives: DATA_TYPE goes to ISSUE with en; HB_TYPE goes to ISSUE with HB_Reset; any other type pulses badPkt and returns to IDLE with fields unchanged.
REQ-024 ISSUE lasts one cycle, pulses exactly one strobe, deasserts busy the following cycle, and returns to IDLE.
REQ-025 Latency: the strobe is asserted exactly N+3 cycles after the pktStart cycle.
REQ-026 pktStart while busy=1 is ignored; it is neither queued nor able to alter the latched base.
REQ-027 en, HB_Reset and badPkt are mutually exclusive; at most one is high per packet.

Reset
REQ-028 nrst=1 immediately forces IDLE, including mid-FETCH, and clears all outputs to 0; no strobe fires for an aborted packet.

Configuration
REQ-029 Macro PKT_CHECKSUM_EN defined: byte 13 is read (N=14) and must equal the XOR of bytes 0-12; on mismatch CHECK pulses badPkt, and en/HB_Reset are suppressed.
REQ-030 PKT_CHECKSUM_EN undefined: no checksum logic; N=13; badPkt only for unknown type.

Verification
REQ-031 Data packet at base 0x010: 02 0029 0003 1000 3000 0002 0029 -> en at cycle N+3; fSourceID=41, fQValue=16'h1000, fChosenCH=41; HB_Reset=0.
REQ-032 Heartbeat at base 0x100, type 01 -> HB_Reset one cycle; en=0; field outputs retain previous packet values.
REQ-033 Type 8'h07 -> badPkt one cycle; no en/HB_Reset; busy low afterwards.
REQ-034 Base 0x7FA -> memRdAddr sequence 7FA..7FF,000..006 (N=13) and correct field assembly.
REQ-035 pktStart re-pulsed during FETCH, then nrst pulsed mid-FETCH -> second start ignored; after reset all outputs 0, no strobe, and a new packet parses normally.
REQ-036 With PKT_CHECKSUM_EN: corrupted checksum byte -> badPkt, en=0; correct XOR -> en.

Source files
------------

// File: rtl/pkt_field_extractor_if.sv
// rtl/pkt_field_extractor_if.sv - packet-memory read bus between extractor and packet RAM
interface pkt_field_extractor_if #(
    parameter int ADDR_W = 11
);
    logic              memRdEn;
    logic [ADDR_W-1:0] memRdAddr;
    logic [7:0]        memRdData;

    modport master (output memRdEn, output memRdAddr, input  memRdData);
    modport slave  (input  memRdEn, input  memRdAddr, output memRdData);
endinterface

// File: rtl/pkt_field_extractor.sv
// rtl/pkt_field_extractor.sv - parses a packet from memory into six 16-bit fields
// Optional PKT_CHECKSUM_EN: reads byte 13 and requires it to equal the XOR of bytes 0-12.
module pkt_field_extractor #(
    parameter int         ADDR_W    = 11,
    parameter logic [7:0] HB_TYPE   = 8'h01,
    parameter logic [7:0] DATA_TYPE = 8'h02
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pktStart,
    input  logic [ADDR_W-1:0]     pktBaseAddr,
    pkt_field_extractor_if.master mem,
    output logic [15:0]           fSourceID,
    output logic [15:0]           fSourceHops,
    output logic [15:0]           fQValue,
    output logic [15:0]           fEnergyLeft,
    output logic [15:0]           fHopsFromCH,
    output logic [15:0]           fChosenCH,
    output logic                  en,
    output logic                  HB_Reset,
    output logic                  busy,
    output logic                  badPkt
);
`ifdef PKT_CHECKSUM_EN
    localparam int N = 14;
`else
    localparam int N = 13;
`endif
    localparam logic [3:0] LAST = 4'(N - 1);

    typedef enum logic [1:0] {IDLE, FETCH, CHECK, ISSUE} state_t;

    state_t      state;
    logic [3:0]  rd_cnt;
    logic [3:0]  rd_idx;
    logic [3:0]  idx_m1;
    logic        rd_vld;
    logic [7:0]  pkt_type;
    logic [15:0] sh [6];
    logic        csum_ok;

`ifdef PKT_CHECKSUM_EN
    logic [7:0]  csum_acc;
    logic [7:0]  csum_rx;
    assign csum_ok = (csum_acc == csum_rx);
`else
    assign csum_ok = 1'b1;
`endif

    // Byte i (1..12) belongs to word (i-1)/2; odd bytes are the high half.
    assign idx_m1 = rd_idx - 4'd1;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state         <= IDLE;
            rd_cnt        <= '0;
            rd_idx        <= '0;
            rd_vld        <= 1'b0;
            pkt_type      <= '0;
            for (int i = 0; i < 6; i++) sh[i] <= '0;
            mem.memRdEn   <= 1'b0;
            mem.memRdAddr <= '0;
            fSourceID     <= '0;
            fSourceHops   <= '0;
            fQValue       <= '0;
            fEnergyLeft   <= '0;
            fHopsFromCH   <= '0;
            fChosenCH     <= '0;
            en            <= 1'b0;
            HB_Reset      <= 1'b0;
            busy          <= 1'b0;
            badPkt        <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum_acc      <= '0;
            csum_rx       <= '0;
`endif
        end else begin
            en       <= 1'b0;
            HB_Reset <= 1'b0;
            badPkt   <= 1'b0;
            rd_vld   <= mem.memRdEn;
            rd_idx   <= rd_cnt;

            if (rd_vld) begin
                if (rd_idx == 4'd0)
                    pkt_type <= mem.memRdData;
                else if (rd_idx <= 4'd12) begin
                    if (rd_idx[0]) sh[idx_m1[3:1]][15:8] <= mem.memRdData;
                    else           sh[idx_m1[3:1]][7:0]  <= mem.memRdData;
                end
`ifdef PKT_CHECKSUM_EN
                if (rd_idx == LAST) csum_rx  <= mem.memRdData;
                else                csum_acc <= csum_acc ^ mem.memRdData;
`endif
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // busy is still high during a badPkt strobe cycle, so starts there are dropped too
                    if (pktStart && !busy) begin
                        mem.memRdEn   <= 1'b1;
                        mem.memRdAddr <= pktBaseAddr;
                        rd_cnt        <= '0;
                        busy          <= 1'b1;
                        state         <= FETCH;
`ifdef PKT_CHECKSUM_EN
                        csum_acc      <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (mem.memRdEn) begin
                        if (rd_cnt == LAST) begin
                            mem.memRdEn <= 1'b0;
                        end else begin
                            mem.memRdAddr <= mem.memRdAddr + 1'b1;
                            rd_cnt        <= rd_cnt + 4'd1;
                        end
                    end
                    if (rd_vld && rd_idx == LAST) state <= CHECK;
                end
                CHECK: begin
                    if (csum_ok && pkt_type == DATA_TYPE) begin
                        en          <= 1'b1;
                        fSourceID   <= sh[0];
                        fSourceHops <= sh[1];
                        fQValue     <= sh[2];
                        fEnergyLeft <= sh[3];
                        fHopsFromCH <= sh[4];
                        fChosenCH   <= sh[5];
                        state       <= ISSUE;
                    end else if (csum_ok && pkt_type == HB_TYPE) begin
                        HB_Reset <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        badPkt <= 1'b1;
                        state  <= IDLE;
                    end
                end
                ISSUE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_field_extractor.sv
// tb/tb_pkt_field_extractor.sv - directed and random packet parsing against a byte-level model
module tb_pkt_field_extractor;
`ifdef PKT_CHECKSUM_EN
    localparam int N = 14;
`else
    localparam int N = 13;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        pktStart;
    logic [10:0] pktBaseAddr;
    logic [15:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
    logic        en, HB_Reset, busy, badPkt;

    pkt_field_extractor_if #(.ADDR_W(11)) mif ();

    pkt_field_extractor dut (
        .clk(clk), .nrst(nrst), .pktStart(pktStart), .pktBaseAddr(pktBaseAddr), .mem(mif),
        .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue),
        .fEnergyLeft(fEnergyLeft), .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
        .en(en), .HB_Reset(HB_Reset), .busy(busy), .badPkt(badPkt)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [2048];
    logic [10:0] addr_q [$];

    always @(posedge clk) begin
        if (mif.memRdEn) begin
            mif.memRdData <= mem[mif.memRdAddr];
            addr_q.push_back(mif.memRdAddr);
        end
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_f [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] fld(input int i);
        case (i)
            0: return fSourceID;
            1: return fSourceHops;
            2: return fQValue;
            3: return fEnergyLeft;
            4: return fHopsFromCH;
            default: return fChosenCH;
        endcase
    endfunction

    function automatic logic [7:0] xsum(input logic [7:0] pb [14]);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 13; i++) x ^= pb[i];
        return x;
    endfunction

    task automatic check_fields(input string tag);
        for (int i = 0; i < 6; i++) check($sformatf("%s_field%0d", tag, i), fld(i), exp_f[i]);
    endtask

    task automatic run_pkt(input logic [10:0] base, input logic [7:0] pb [14]);
        logic [2:0] exp_k, got_k;
        int lat, nstrobe;
        bit ok;
        for (int i = 0; i < N; i++) mem[11'(base + i)] = pb[i];
        ok = 1'b1;
`ifdef PKT_CHECKSUM_EN
        ok = (xsum(pb) == pb[13]);
`endif
        exp_k = !ok ? 3'b001 : (pb[0] == 8'h02) ? 3'b100 : (pb[0] == 8'h01) ? 3'b010 : 3'b001;
        addr_q.delete();
        @(posedge clk); #1 pktStart = 1'b1; pktBaseAddr = base;
        @(posedge clk); #1 pktStart = 1'b0;
        lat = 0; nstrobe = 0; got_k = 3'b000;
        for (int c = 1; c <= N + 8; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_rise", busy, 1);
            if (en | HB_Reset | badPkt) begin
                nstrobe++;
                if (lat == 0) begin
                    lat = c;
                    got_k = {en, HB_Reset, badPkt};
                    check("busy_at_strobe", busy, 1);
                end
            end
            if (c == N + 4) check("busy_fall", busy, 0);
        end
        check("latency", lat, N + 3);
        check("strobe_kind", got_k, exp_k);
        check("strobe_count", nstrobe, 1);
        if (exp_k == 3'b100)
            for (int i = 0; i < 6; i++) exp_f[i] = {pb[2*i+1], pb[2*i+2]};
        check_fields("pkt");
        check("rd_count", addr_q.size(), N);
        for (int i = 0; i < addr_q.size() && i < N; i++) check("rd_addr", addr_q[i], 11'(base + i));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"}, en, 0);
        check({tag, "_hb"}, HB_Reset, 0);
        check({tag, "_bad"}, badPkt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rden"}, mif.memRdEn, 0);
        check_fields(tag);
    endtask

    logic [7:0] p [14];
    int strobes, rds;

    initial begin
        nrst = 1'b1; pktStart = 1'b0; pktBaseAddr = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) exp_f[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 nrst = 1'b0;

        // Neighbour-info packet with known words
        p = '{8'h02, 8'h00, 8'h29, 8'h00, 8'h03, 8'h10, 8'h00, 8'h30, 8'h00,
              8'h00, 8'h02, 8'h00, 8'h29, 8'h00};
        p[13] = xsum(p);
        run_pkt(11'h010, p);
        check("src_id_41", fSourceID, 16'd41);
        check("qvalue", fQValue, 16'h1000);
        check("chosen_ch_41", fChosenCH, 16'd41);

        // Heartbeat: fields must keep the previous packet's values
        for (int i = 1; i < 14; i++) p[i] = 8'($urandom);
        p[0] = 8'h01; p[13] = xsum(p);
        run_pkt(11'h100, p);

        // Unknown type
        p[0] = 8'h07; p[13] = xsum(p);
        run_pkt(11'h300, p);

        // Base near top of memory wraps to address 0
        for (int i = 1; i < 14; i++) p[i] = 8'($urandom);
        p[0] = 8'h02; p[13] = xsum(p);
        run_pkt(11'h7FA, p);

`ifdef PKT_CHECKSUM_EN
        for (int i = 1; i < 14; i++) p[i] = 8'($urandom);
        p[0] = 8'h02; p[13] = xsum(p) ^ 8'h01;
        run_pkt(11'h040, p);
        p[13] = xsum(p);
        run_pkt(11'h040, p);
`endif

        // Second start during FETCH is ignored, then reset aborts the packet
        for (int i = 1; i < 14; i++) p[i] = 8'($urandom);
        p[0] = 8'h02;
        for (int i = 0; i < 14; i++) mem[11'(11'h200 + i)] = p[i];
        @(posedge clk); #1 pktStart = 1'b1; pktBaseAddr = 11'h200;
        @(posedge clk); #1 pktStart = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        pktStart = 1'b1; pktBaseAddr = 11'h555;
        @(posedge clk); #1 pktStart = 1'b0;
        @(negedge clk);
        check("ignored_start_addr", mif.memRdAddr, 11'h204);
        check("ignored_start_busy", busy, 1);
        @(posedge clk); #1 nrst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) exp_f[i] = 16'h0000;
        check_quiet("async_reset");
        @(posedge clk); #1 nrst = 1'b0;
        addr_q.delete();
        strobes = 0; rds = 0;
        for (int c = 0; c < N + 6; c++) begin
            @(negedge clk);
            if (en | HB_Reset | badPkt) strobes++;
            if (mif.memRdEn) rds++;
        end
        check("abort_no_strobe", strobes, 0);
        check("abort_no_reads", rds, 0);
        check_quiet("after_abort");

        p[13] = xsum(p);
        run_pkt(11'h200, p);

        // Random packets: mixed types, bases and checksum corruption
        for (int k = 0; k < 24; k++) begin
            int t;
            for (int i = 0; i < 14; i++) p[i] = 8'($urandom);
            t = $urandom_range(0, 3);
            p[0] = (t < 2) ? 8'h02 : (t == 2) ? 8'h01 : p[0];
            p[13] = xsum(p);
            if ($urandom_range(0, 3) == 0) p[13] ^= 8'h5A;
            run_pkt(11'($urandom), p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
